mmio_hub: RTL and testbench
===========================

# mmio_hub

Parametrised memory-mapped IO hub between the Hack CPU data bus and the on-chip peripherals. Decodes one 16-bit address space into a RAM window of 2^RAM_AW words and an IO window directly above it. The IO window holds GPIO, a FIFO-buffered UART byte interface, sticky error flags and a level interrupt. It replaces the fixed 2 KiB / 2-LED / unbuffered-UART decoder and connects to UartTX/UartRX at byte level and to an external RAM.

## Interface
Parameters:
- RAM_AW, 11: RAM window address width; RAM occupies 0 .. 2^RAM_AW-1; IO_BASE = 2^RAM_AW; legal range 4..15.
- GPIO_W, 2: number of LED outputs and button inputs; legal range 1..16.
- FIFO_AW, 4: UART FIFO depth = 2^FIFO_AW bytes, one FIFO per direction.

Ports (one clock; reset is synchronous and active-low):
- CLK_100MHz  in  1  sole clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- address  in  16  word address from CPU.
- dataW  in  16  write data.
- we  in  1  single-cycle write strobe.
- re  in  1  single-cycle read strobe; needed only for side-effecting reads (RX pop).
- dataR  out  16  registered read data.
- ram_addr  out  RAM_AW  = address[RAM_AW-1:0].
- ram_we  out  1  = we when address < IO_BASE, else 0 (combinational).
- ram_wdata  out  16  = dataW.
- ram_rdata  in  16  combinational read data for ram_addr.
- but  in  GPIO_W  raw buttons, asynchronous.
- led  out  GPIO_W  LED register.
- tx_data  out  8  head of TX FIFO.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  UartTX idle; byte consumed when tx_valid & tx_ready.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle pulse, rx_data valid.
- irq  out  1  registered level interrupt.

## Operation
- IO register offsets from IO_BASE:
  - +0 LED: RW; bits [GPIO_W-1:0], upper bits read 0.
  - +1 BUTTON: RO; 2-flop-synchronised but.
  - +2 UART_RX: RO. Read with re returns {1'b1, 7'b0, head} and pops. If empty, returns 0x0000, no pop. Read without re returns the same value, no pop.
  - +3 UART_TX: a write pushes dataW[7:0]. If full, the byte is dropped and TX_OVF is set. Read returns {tx_full, 15'b0}.
  - +4 STATUS: [0] rx_nonempty, [1] tx_full, [2] tx_empty, [3] RX_OVF sticky, [4] TX_OVF sticky, [15:8] rx_count zero-extended. Writing 1 to bit 3 or bit 4 clears that flag; other bits are read-only.
  - +5 IRQ_EN: RW bits [1:0]; all other bits read 0.
- Any other IO_BASE+n: reads 0x0000; writes are ignored.
- RX path: a push occurs on rx_valid. If the FIFO is full and no pop occurs that cycle, the byte is dropped and RX_OVF is set. Push and pop in the same cycle when full: both succeed, no overflow.
- TX path: pop occurs on tx_valid & tx_ready. CPU push and UART pop in the same cycle when full: the push succeeds.
- irq_next = (IRQ_EN[0] & rx_nonempty) | (IRQ_EN[1] & tx_empty) | RX_OVF | TX_OVF.
- FIFO pointers are FIFO_AW+1 bits; full/empty are derived from the MSB compare; wrap-around is modulo 2^FIFO_AW.

## Timing
- Reset values (reset_n=0 at an edge):
  - dataR, led, IRQ_EN = 0.
  - Sticky flags = 0; irq = 0.
  - Both FIFOs empty, so tx_valid = 0 from the next cycle.
  - Synchroniser flops = 0.
- Reset mid-operation flushes FIFO contents. A byte already accepted by UartTX is not recalled.
- Read latency: 1 cycle. dataR after edge k reflects address and state sampled at edge k. An RX pop and its returned value occur at the same edge.
- Write effects land at the edge where we=1 and are visible to a read addressed in the next cycle.
- BUTTON lags the pin by 2 cycles; irq lags its cause by 1 cycle.
- A write and a W1C on the same edge as a new overflow: set wins.

## Structure
- Package mmio_pkg:
  - register offset localparams;
  - STATUS bit indices;
  - IRQ_EN bit indices.
- Sub-module sync_fifo (WIDTH, AW), instantiated twice with WIDTH=8. Ports:
  - push, pop, din, dout;
  - full, empty, count.
- Top level contains the decode, the registers, the synchroniser and the irq logic.

## Test plan
- Reset, then read each IO offset 0..7 with defaults -> all 0x0000 except STATUS = 0x0004; irq=0.
- Write 0x1234 to address 5, read back 1 cycle later -> ram_we pulses once and dataR = ram_rdata. Write to 2048 -> ram_we stays 0 and led = 2'b00.
- Push 17 rx_valid bytes 0x00..0x10 with FIFO_AW=4 -> RX_OVF set and rx_count=16. 16 re-reads of 2050 return 0x8000..0x800F; the 17th returns 0x0000. Writing 0x0008 to STATUS clears RX_OVF.
- Hold tx_ready=0, write 17 bytes to 2051 -> tx_full=1, TX_OVF=1. Release tx_ready -> bytes 0..15 leave in order and tx_valid drops after the 16th.
- RX FIFO full, rx_valid coincident with re-read of 2050 -> no overflow; count stays 16; head advances.
- IRQ_EN=0x2 with TX empty -> irq=1 one cycle after the write. Assert reset_n=0 mid-stream with 5 queued TX bytes -> tx_valid=0 and irq=0 on the following cycle.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the memory-mapped IO hub.
//   - IO register offsets relative to IO_BASE
//   - STATUS register bit positions
//   - IRQ_EN register bit positions
package mmio_pkg;

    localparam logic [15:0] OFF_LED     = 16'd0;
    localparam logic [15:0] OFF_BUTTON  = 16'd1;
    localparam logic [15:0] OFF_UART_RX = 16'd2;
    localparam logic [15:0] OFF_UART_TX = 16'd3;
    localparam logic [15:0] OFF_STATUS  = 16'd4;
    localparam logic [15:0] OFF_IRQ_EN  = 16'd5;

    localparam int unsigned ST_RX_NONEMPTY  = 0;
    localparam int unsigned ST_TX_FULL      = 1;
    localparam int unsigned ST_TX_EMPTY     = 2;
    localparam int unsigned ST_RX_OVF       = 3;
    localparam int unsigned ST_TX_OVF       = 4;
    localparam int unsigned ST_RX_COUNT_LSB = 8;

    localparam int unsigned IRQ_EN_RX = 0;
    localparam int unsigned IRQ_EN_TX = 1;

endpackage

// File: rtl/mmio_hub_sync_fifo.sv
// sync_fifo: single-clock FIFO of 2^AW entries, WIDTH bits each.
//   clk_i, rst_ni : clock, synchronous active-low reset (flushes pointers)
//   push_i, din_i : write request and data
//   pop_i, dout_o : read request and head-of-queue data (combinational)
//   full_o, empty_o, count_o : occupancy
// A push while full is accepted only if a pop happens in the same cycle.
// A pop while empty is ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             push_ok, pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push_ok) wr_d = wr_q + (AW+1)'(1);
        if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: Hack CPU data-bus decoder. Addresses below IO_BASE = 2^RAM_AW go
// to external RAM; IO_BASE and above form the IO window (LED, BUTTON,
// UART RX/TX FIFOs, STATUS, IRQ_EN).
//   CLK_100MHz, reset_n : clock, synchronous active-low reset
//   address, dataW, we, re, dataR : CPU bus (dataR registered, 1-cycle latency)
//   ram_addr, ram_we, ram_wdata, ram_rdata : external RAM port
//   but, led : GPIO (buttons are asynchronous, 2-flop synchronised)
//   tx_data, tx_valid, tx_ready : byte stream towards UartTX
//   rx_data, rx_valid : byte stream from UartRX
//   irq : registered level interrupt
module mmio_hub #(
    parameter int unsigned RAM_AW  = 11,
    parameter int unsigned GPIO_W  = 2,
    parameter int unsigned FIFO_AW = 4
) (
    input  logic              CLK_100MHz,
    input  logic              reset_n,
    input  logic [15:0]       address,
    input  logic [15:0]       dataW,
    input  logic              we,
    input  logic              re,
    output logic [15:0]       dataR,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    input  logic [GPIO_W-1:0] but,
    output logic [GPIO_W-1:0] led,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              irq
);

    import mmio_pkg::*;

    localparam logic [15:0] IO_BASE = 16'(1 << RAM_AW);

    logic              io_sel;
    logic [15:0]       io_off;
    logic              wr_led, wr_tx, wr_status, wr_irq_en, rx_pop, tx_pop;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [7:0]        rx_head;
    logic [FIFO_AW:0]  rx_count, tx_count_unused;
    logic              rx_ovf_set, tx_ovf_set;

    logic [15:0]       dataR_q, dataR_d;
    logic [GPIO_W-1:0] led_q, led_d;
    logic [1:0]        irq_en_q, irq_en_d;
    logic              rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, irq_q, irq_d;
    logic [GPIO_W-1:0] but_meta_q, but_sync_q;

    assign io_sel    = (address >= IO_BASE);
    assign io_off    = address - IO_BASE;
    assign ram_addr  = address[RAM_AW-1:0];
    assign ram_we    = we & ~io_sel;
    assign ram_wdata = dataW;

    assign wr_led    = we & io_sel & (io_off == OFF_LED);
    assign wr_tx     = we & io_sel & (io_off == OFF_UART_TX);
    assign wr_status = we & io_sel & (io_off == OFF_STATUS);
    assign wr_irq_en = we & io_sel & (io_off == OFF_IRQ_EN);
    assign rx_pop    = re & io_sel & (io_off == OFF_UART_RX);
    assign tx_valid  = ~tx_empty;
    assign tx_pop    = tx_valid & tx_ready;

    // A full FIFO still takes a byte when the opposite side drains one that cycle.
    assign rx_ovf_set = rx_valid & rx_full & ~rx_pop;
    assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;

    sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk_i   (CLK_100MHz),
        .rst_ni  (reset_n),
        .push_i  (rx_valid),
        .pop_i   (rx_pop),
        .din_i   (rx_data),
        .dout_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk_i   (CLK_100MHz),
        .rst_ni  (reset_n),
        .push_i  (wr_tx),
        .pop_i   (tx_pop),
        .din_i   (dataW[7:0]),
        .dout_o  (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count_unused)
    );

    always_comb begin
        dataR_d = '0;
        if (!io_sel) begin
            dataR_d = ram_rdata;
        end else begin
            case (io_off)
                OFF_LED:     dataR_d[GPIO_W-1:0] = led_q;
                OFF_BUTTON:  dataR_d[GPIO_W-1:0] = but_sync_q;
                OFF_UART_RX: if (!rx_empty) dataR_d = {1'b1, 7'b0, rx_head};
                OFF_UART_TX: dataR_d[15] = tx_full;
                OFF_STATUS: begin
                    dataR_d[ST_RX_NONEMPTY]         = ~rx_empty;
                    dataR_d[ST_TX_FULL]             = tx_full;
                    dataR_d[ST_TX_EMPTY]            = tx_empty;
                    dataR_d[ST_RX_OVF]              = rx_ovf_q;
                    dataR_d[ST_TX_OVF]              = tx_ovf_q;
                    dataR_d[ST_RX_COUNT_LSB +: 8]   = 8'(rx_count);
                end
                OFF_IRQ_EN:  dataR_d[1:0] = irq_en_q;
                default:     dataR_d = '0;
            endcase
        end
    end

    always_comb begin
        led_d    = wr_led    ? dataW[GPIO_W-1:0] : led_q;
        irq_en_d = wr_irq_en ? dataW[1:0]        : irq_en_q;
        // New overflow wins over a simultaneous write-1-to-clear.
        rx_ovf_d = rx_ovf_set | (rx_ovf_q & ~(wr_status & dataW[ST_RX_OVF]));
        tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~(wr_status & dataW[ST_TX_OVF]));
        irq_d    = (irq_en_q[IRQ_EN_RX] & ~rx_empty) | (irq_en_q[IRQ_EN_TX] & tx_empty)
                 | rx_ovf_q | tx_ovf_q;
    end

    always_ff @(posedge CLK_100MHz) begin
        if (!reset_n) begin
            dataR_q    <= '0;
            led_q      <= '0;
            irq_en_q   <= '0;
            rx_ovf_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
            irq_q      <= 1'b0;
            but_meta_q <= '0;
            but_sync_q <= '0;
        end else begin
            dataR_q    <= dataR_d;
            led_q      <= led_d;
            irq_en_q   <= irq_en_d;
            rx_ovf_q   <= rx_ovf_d;
            tx_ovf_q   <= tx_ovf_d;
            irq_q      <= irq_d;
            but_meta_q <= but;
            but_sync_q <= but_meta_q;
        end
    end

    assign dataR = dataR_q;
    assign led   = led_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_mmio_hub.sv
module tb_mmio_hub;

    localparam int RAM_AW  = 11;
    localparam int GPIO_W  = 2;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int IO_BASE = 1 << RAM_AW;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [15:0]       address, dataW, dataR, ram_wdata, ram_rdata;
    logic              we, re, ram_we, tx_valid, tx_ready, rx_valid, irq;
    logic [RAM_AW-1:0] ram_addr;
    logic [GPIO_W-1:0] but, led;
    logic [7:0]        tx_data, rx_data;

    always #5 clk = ~clk;

    // External RAM: combinational read, contents maintained by the reference model.
    logic [15:0] ram [0:IO_BASE-1];
    assign ram_rdata = ram[ram_addr];

    mmio_hub #(.RAM_AW(RAM_AW), .GPIO_W(GPIO_W), .FIFO_AW(FIFO_AW)) dut (
        .CLK_100MHz (clk),
        .reset_n    (reset_n),
        .address    (address),
        .dataW      (dataW),
        .we         (we),
        .re         (re),
        .dataR      (dataR),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .but        (but),
        .led        (led),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .irq        (irq)
    );

    // Reference model state
    logic [7:0]        rxq[$];
    logic [7:0]        txq[$];
    logic              m_rxovf, m_txovf;
    logic [GPIO_W-1:0] m_led;
    logic [1:0]        m_en;
    logic [GPIO_W-1:0] but_hist[$];   // button values seen at past edges, newest last
    logic              g_tr;
    logic [GPIO_W-1:0] g_but;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_rxovf = 1'b0;
        m_txovf = 1'b0;
        m_led   = '0;
        m_en    = '0;
        but_hist.delete();
        but_hist.push_back('0);
        but_hist.push_back('0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; we = 1'b0; re = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        address = '0; dataW = '0; rx_data = '0; but = '0;
        @(posedge clk); #1;
        model_reset();
        chk("rst_tx_valid", 16'(tx_valid), 16'h0);
        chk("rst_irq", 16'(irq), 16'h0);
        chk("rst_dataR", dataR, 16'h0);
        chk("rst_led", 16'(led), 16'h0);
        reset_n = 1'b1;
    endtask

    // One bus cycle: drive inputs, check combinational outputs, clock, check registered outputs.
    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r,
                        input logic rv, input logic [7:0] rd);
        logic [15:0] exp_rd;
        logic        exp_irq, io, new_rxovf, new_txovf, exp_ramwe;
        int          off;
        address = a; dataW = d; we = w; re = r; rx_valid = rv; rx_data = rd;
        tx_ready = g_tr; but = g_but;
        #1;
        io        = (int'(a) >= IO_BASE);
        off       = int'(a) - IO_BASE;
        exp_ramwe = w && !io;
        chk("ram_we", 16'(ram_we), 16'(exp_ramwe));
        chk("ram_addr", 16'(ram_addr), 16'(int'(a) % IO_BASE));
        chk("tx_valid", 16'(tx_valid), 16'(txq.size() != 0));
        if (txq.size() != 0) chk("tx_data", 16'(tx_data), 16'(txq[0]));

        exp_rd = '0;
        if (!io) exp_rd = ram[int'(a)];
        else case (off)
            0: exp_rd = 16'(m_led);
            1: exp_rd = 16'(but_hist[but_hist.size()-2]);
            2: if (rxq.size() != 0) exp_rd = 16'h8000 + 16'(rxq[0]);
            3: exp_rd = (txq.size() == DEPTH) ? 16'h8000 : 16'h0000;
            4: exp_rd = 16'(rxq.size()) * 16'd256 + 16'(m_txovf) * 16'd16 + 16'(m_rxovf) * 16'd8
                      + ((txq.size() == 0) ? 16'd4 : 16'd0) + ((txq.size() == DEPTH) ? 16'd2 : 16'd0)
                      + ((rxq.size() != 0) ? 16'd1 : 16'd0);
            5: exp_rd = 16'(m_en);
            default: exp_rd = '0;
        endcase
        exp_irq = (m_en[0] && rxq.size() != 0) || (m_en[1] && txq.size() == 0) || m_rxovf || m_txovf;

        new_rxovf = m_rxovf;
        new_txovf = m_txovf;
        if (r && io && off == 2 && rxq.size() != 0) void'(rxq.pop_front());
        if (g_tr && txq.size() != 0) void'(txq.pop_front());
        if (w && io && off == 4) begin
            if (d[3]) new_rxovf = 1'b0;
            if (d[4]) new_txovf = 1'b0;
        end
        if (rv) begin
            if (rxq.size() < DEPTH) rxq.push_back(rd);
            else new_rxovf = 1'b1;
        end
        if (w && io && off == 3) begin
            if (txq.size() < DEPTH) txq.push_back(d[7:0]);
            else new_txovf = 1'b1;
        end
        if (w && io && off == 0) m_led = d[GPIO_W-1:0];
        if (w && io && off == 5) m_en = d[1:0];
        but_hist.push_back(g_but);
        void'(but_hist.pop_front());

        @(posedge clk); #1;
        if (exp_ramwe) ram[int'(a)] = d;
        m_rxovf = new_rxovf;
        m_txovf = new_txovf;
        chk("dataR", dataR, exp_rd);
        chk("irq", 16'(irq), 16'(exp_irq));
        chk("led", 16'(led), 16'(m_led));
    endtask

    task automatic rd(input int a, input logic r);
        step(16'(a), 16'h0, 1'b0, r, 1'b0, 8'h00);
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        step(16'(a), d, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < IO_BASE; i++) ram[i] = 16'($urandom);
        g_tr = 1'b0;
        g_but = '0;
        do_reset();
        do_reset();

        // Defaults of every IO offset
        for (int i = 0; i < 8; i++) begin
            rd(IO_BASE + i, 1'b0);
            chk("dflt_io", dataR, (i == 4) ? 16'h0004 : 16'h0000);
        end

        // RAM write then read; write into IO base must not touch RAM or LED bit pattern 00
        wr(5, 16'h1234);
        rd(5, 1'b0);
        chk("ram_rb", dataR, 16'h1234);
        wr(IO_BASE, 16'h1234);
        chk("led_00", 16'(led), 16'h0000);
        wr(IO_BASE, 16'h0003);
        chk("led_11", 16'(led), 16'h0003);

        // Buttons through the synchroniser
        g_but = 2'b10;
        for (int i = 0; i < 4; i++) rd(IO_BASE + 1, 1'b0);
        chk("button", dataR, 16'h0002);
        g_but = '0;

        // RX overflow: 17 bytes into a 16-deep FIFO
        for (int i = 0; i <= 16; i++) step(16'h0000, 16'h0, 1'b0, 1'b0, 1'b1, 8'(i));
        rd(IO_BASE + 4, 1'b0);
        chk("rx_ovf_status", dataR, 16'h100D);
        for (int i = 0; i <= 16; i++) begin
            rd(IO_BASE + 2, 1'b1);
            chk("rx_pop", dataR, (i < 16) ? (16'h8000 + 16'(i)) : 16'h0000);
        end
        wr(IO_BASE + 4, 16'h0008);
        rd(IO_BASE + 4, 1'b0);
        chk("rx_ovf_clr", dataR, 16'h0004);

        // TX overflow with UART stalled, then drain
        g_tr = 1'b0;
        for (int i = 0; i <= 16; i++) wr(IO_BASE + 3, 16'(i));
        rd(IO_BASE + 3, 1'b0);
        chk("tx_full_rd", dataR, 16'h8000);
        rd(IO_BASE + 4, 1'b0);
        chk("tx_ovf_status", dataR, 16'h0012);
        g_tr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #0 chk("tx_order", 16'(tx_data), 16'(i));
            rd(0, 1'b0);
        end
        chk("tx_drained", 16'(tx_valid), 16'h0);
        wr(IO_BASE + 4, 16'h0010);

        // RX full with simultaneous push and pop: no overflow
        for (int i = 0; i < 16; i++) step(16'h0000, 16'h0, 1'b0, 1'b0, 1'b1, 8'(8'hA0 + i));
        step(16'(IO_BASE + 2), 16'h0, 1'b0, 1'b1, 1'b1, 8'h55);
        chk("rx_pushpop", dataR, 16'h80A0);
        rd(IO_BASE + 4, 1'b0);
        chk("rx_pushpop_st", dataR, 16'h1005);
        for (int i = 0; i < 16; i++) rd(IO_BASE + 2, 1'b1);
        chk("rx_last", dataR, 16'h8055);

        // TX-empty interrupt
        wr(IO_BASE + 5, 16'h0002);
        rd(0, 1'b0);
        chk("irq_tx_empty", 16'(irq), 16'h1);

        // Reset mid-stream with queued TX bytes and a pending RX interrupt
        g_tr = 1'b0;
        wr(IO_BASE + 5, 16'h0001);
        for (int i = 0; i < 5; i++) wr(IO_BASE + 3, 16'(8'hC0 + i));
        step(16'h0000, 16'h0, 1'b0, 1'b0, 1'b1, 8'h77);
        rd(0, 1'b0);
        chk("irq_rx_pre_rst", 16'(irq), 16'h1);
        do_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int a;
            g_tr  = 1'($urandom_range(0, 1));
            g_but = GPIO_W'($urandom);
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : IO_BASE + int'($urandom_range(0, 8));
            step(16'(a), 16'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
